// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: weight word, weight-buffer FSM states and default geometry.
package cnn_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int KERNEL_SIZE_DEF = 9;
    localparam int NUM_CH_DEF      = 4;

    typedef logic [DATA_WIDTH_DEF-1:0] weight_t;

    typedef enum logic {FILL, FULL} wbuf_state_t;

endpackage

// File: rtl/weight_bank.sv
// One DEPTH-entry register bank: single write port, async clear, full parallel read.
module weight_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 36,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_we,
    input  logic [AW-1:0]                     i_addr,
    input  logic [DATA_WIDTH-1:0]             i_wdata,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]  o_rdata
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem;

endmodule

// File: rtl/weight_bank_buffer.sv
// Double-buffered kernel weight store: compute reads the active bank while the
// loader fills the shadow bank; a swap handshake exchanges them between layers.
module weight_bank_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int DEPTH       = NUM_CH * KERNEL_SIZE,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                load_valid,
    input  logic [DATA_WIDTH-1:0]                               load_data,
    output logic                                                load_ready,
    input  logic                                                clear,
    input  logic                                                swap_req,
    output logic                                                swap_ack,
    output logic                                                shadow_full,
    output logic [AW:0]                                         fill_count,
    output logic [0:NUM_CH-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0]  weights,
    output logic                                                weights_valid
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    wbuf_state_t r_state;
    wbuf_state_t w_next_state;
    logic [AW:0] r_fill_count;
    logic        r_active_sel;
    logic        r_weights_valid;
    logic        r_swap_ack;

    logic        w_accept;
    logic        w_swap;
    logic [1:0]  w_we;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_rdata0;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_rdata1;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_active;

    // clear outranks both a load beat and a swap arriving in the same cycle
    assign w_accept = load_valid && (r_state == FILL) && !clear;
    assign w_swap   = swap_req && (r_state == FULL) && !clear;
    assign w_we[0]  = w_accept &&  r_active_sel;
    assign w_we[1]  = w_accept && !r_active_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = FILL;
        end else begin
            case (r_state)
                FILL:    if (w_accept && (r_fill_count == LAST_IDX)) w_next_state = FULL;
                FULL:    if (w_swap) w_next_state = FILL;
                default: w_next_state = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_count    <= '0;
            r_active_sel    <= 1'b0;
            r_weights_valid <= 1'b0;
            r_swap_ack      <= 1'b0;
        end else begin
            r_swap_ack <= w_swap;
            if (clear || w_swap) begin
                r_fill_count <= '0;
            end else if (w_accept) begin
                r_fill_count <= r_fill_count + 1'b1;
            end
            if (w_swap) begin
                r_active_sel    <= ~r_active_sel;
                r_weights_valid <= 1'b1;
            end
        end
    end

    weight_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we[0]),
        .i_addr  (r_fill_count[AW-1:0]),
        .i_wdata (load_data),
        .o_rdata (w_rdata0)
    );

    weight_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we[1]),
        .i_addr  (r_fill_count[AW-1:0]),
        .i_wdata (load_data),
        .o_rdata (w_rdata1)
    );

    assign w_active = r_active_sel ? w_rdata1 : w_rdata0;

    always_comb begin
        weights = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                weights[c][k] = w_active[c*KERNEL_SIZE + k];
            end
        end
    end

    assign load_ready    = (r_state == FILL);
    assign shadow_full   = (r_state == FULL);
    assign fill_count    = r_fill_count;
    assign swap_ack      = r_swap_ack;
    assign weights_valid = r_weights_valid;

endmodule
